muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with its own sequencer, owning the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Operations are launched from the Execute stage.
- The block runs for a fixed 33 cycles while the pipeline keeps flowing.
- It raises stallMD to the hazard unit when a Decode-stage instruction needs HI/LO, or needs the unit itself, while an operation is in flight.
- stallMD is ORed into the existing StallF/StallD/FlushE terms.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
startE  input  1  Execute holds a MULT/MULTU/DIV/DIVU this cycle
opE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
SrcAE  input  WIDTH  rs operand (multiplicand / dividend)
SrcBE  input  WIDTH  rt operand (multiplier / divisor)
mthiE  input  1  write SrcAE to HI
mtloE  input  1  write SrcAE to LO
hiloReadD  input  1  Decode holds MFHI/MFLO
muldivD  input  1  Decode holds MULT/DIV/MTHI/MTLO
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse: hi/lo just updated by an operation
stallMD  output  1  stall request to the hazard unit

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, stallMD=0. Reset asserted mid-operation aborts the operation with no partial HI/LO update.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; counter counts 0..WIDTH-1.
  - FIX: busy=1; a single cycle.
- IDLE, startE=1: at the clock edge latch operand magnitudes and the sign flags, then go to RUN.
  - Signed ops (opE[0]=0) take the two's-complement absolute value of each operand.
  - Unsigned ops use the operands as-is.
  - Negation result sign = signA XOR signB. Remainder sign = signA.
- RUN, multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
- RUN, divide: one restoring shift-subtract step per cycle, producing 1 quotient bit and a partial remainder.
- RUN exit: after WIDTH steps (counter==WIDTH-1) go to FIX.
- FIX: apply sign correction and write the results, then return to IDLE with done=1 in that same edge's output cycle.
  - Multiply: {hi,lo} = signed/unsigned product.
  - Divide: lo = quotient, hi = remainder.
- Latency: startE sampled at edge 0 gives busy=1 for cycles 1..33, with hi/lo valid and done=1 in cycle 34. No early termination.
- Divide by zero: no trap. Completes in the same latency with lo=all-ones magnitude (sign-corrected for DIV), hi=dividend.
- Overflow case: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the magnitude path (negation wraps).
- MTHI/MTLO: honoured only in IDLE; hi/lo update at the next edge.
  - If mthiE and mtloE are both high, both registers are written.
  - If startE and mt*E are both high in IDLE, startE wins and mt* is ignored.
- startE or mt*E while busy is ignored. This is a protocol violation that stallMD prevents.
- stallMD = busy AND (hiloReadD OR muldivD). Combinational, no registered delay.
  - In the FIX cycle, stallMD is still high.
  - MFHI in Decode then reads the updated hi one cycle later, via the register value. No bypass of the in-flight result.
- hi/lo are stable except on FIX or mt* edges.
- done is high exactly one cycle per completed operation.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, startE pulse → busy 33 cycles; done cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFE (-2) × 3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; also MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 → lo=3, hi=1; DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- DIVU 5/0 → after 33 busy cycles lo=0xFFFFFFFF, hi=5; no hang.
- Hazards: hiloReadD=1 from cycle 5 of an op → stallMD=1 through the FIX cycle, 0 after done. Idle MTHI 0x1234 with startE=0 → hi=0x1234 next cycle. Same-cycle startE+mtloE → lo unchanged by mt.
- Reset asserted at cycle 10 of a MULT → busy, done and stallMD drop asynchronously, hi=lo=0. A new op after release completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Iterative 33-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             mthiE,
    input  logic             mtloE,
    input  logic             hiloReadD,
    input  logic             muldivD,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stallMD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_isdiv;
    logic                 r_negq;
    logic                 r_negr;
    logic                 r_done;

    logic                 w_signA;
    logic                 w_signB;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_div_nxt;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_signA = ~opE[0] & SrcAE[WIDTH-1];
    assign w_signB = ~opE[0] & SrcBE[WIDTH-1];
    assign w_absA  = w_signA ? -SrcAE : SrcAE;
    assign w_absB  = w_signB ? -SrcBE : SrcBE;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply: {carry, upper half} absorbs the addend, then the whole accumulator shifts right.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_b};
    assign w_div_nxt = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_negq ? -r_acc : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (startE) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_isdiv <= 1'b0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (startE) begin
                        r_isdiv <= opE[1];
                        r_negq  <= w_signA ^ w_signB;
                        r_negr  <= w_signA;
                        r_acc   <= {{WIDTH{1'b0}}, (opE[1] ? w_absA : w_absB)};
                        r_b     <= opE[1] ? w_absB : w_absA;
                    end else begin
                        if (mthiE) r_hi <= SrcAE;
                        if (mtloE) r_lo <= SrcAE;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= r_isdiv ? w_div_nxt : w_mul_nxt;
                end
                S_FIX: begin
                    r_cnt <= '0;
                    if (r_isdiv) begin
                        r_lo <= r_negq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        r_hi <= r_negr ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign stallMD = busy & (hiloReadD | muldivD);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Scoreboard bench for muldiv_sequencer using directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        mthiE;
    logic        mtloE;
    logic        hiloReadD;
    logic        muldivD;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stallMD;

    int          checks;
    int          failures;
    logic [63:0] sb_q[$];

    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .startE    (startE),
        .opE       (opE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .mthiE     (mthiE),
        .mtloE     (mtloE),
        .hiloReadD (hiloReadD),
        .muldivD   (muldivD),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stallMD   (stallMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done=1 expected no pending result");
            end else begin
                check("hilo_result", {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Launch one op; counts busy cycles, optionally raises hiloReadD from cycle 5 and
    // optionally fires mtloE together with startE (the mt write must be ignored).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit hazard, input bit with_mtlo);
        int          c;
        int          nbusy;
        logic [31:0] lo_before;
        lo_before = lo;
        startE = 1'b1; opE = op; SrcAE = a; SrcBE = b; mtloE = with_mtlo;
        sb_q.push_back({exp_hi, exp_lo});
        @(posedge clk); #1;
        startE = 1'b0; mtloE = 1'b0; SrcAE = '0; SrcBE = '0;
        c = 1; nbusy = 0;
        while (c < 100) begin
            if (hazard && c >= 5) hiloReadD = 1'b1;
            @(negedge clk);
            if (with_mtlo && c == 1) check("mtlo_ignored_on_start", {32'd0, lo}, {32'd0, lo_before});
            if (!busy) break;
            nbusy++;
            if (hazard) check("stall_in_flight", {63'd0, stallMD}, {63'd0, (c >= 5)});
            @(posedge clk); #1;
            c++;
        end
        if (c >= 100) begin
            checks++; failures++;
            $display("FAIL busy_timeout: got busy after %0d cycles expected idle by 34", c);
        end
        check("busy_cycles", 64'(nbusy), 64'd33);
        check("done_cycle34", {63'd0, done}, 64'd1);
        if (hazard) check("stall_after_done", {63'd0, stallMD}, 64'd0);
        @(posedge clk); #1;
        hiloReadD = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; startE = 1'b0; opE = 2'b00; SrcAE = '0; SrcBE = '0;
        mthiE = 1'b0; mtloE = 1'b0; hiloReadD = 1'b1; muldivD = 1'b1;
        @(negedge clk);
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, stallMD}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; hiloReadD = 1'b0; muldivD = 1'b0;

        // Idle MTHI, then MTLO to seed a known LO.
        mthiE = 1'b1; SrcAE = 32'h0000_1234;
        @(posedge clk); #1;
        mthiE = 1'b0;
        @(negedge clk);
        check("mthi_write", {32'd0, hi}, 64'h0000_1234);
        check("mthi_lo_untouched", {32'd0, lo}, 64'd0);
        @(posedge clk); #1;
        mtloE = 1'b1; SrcAE = 32'hAAAA_5555;
        @(posedge clk); #1;
        mtloE = 1'b0;
        @(negedge clk);
        check("mtlo_write", {hi, lo}, 64'h0000_1234_AAAA_5555);
        @(posedge clk); #1;

        run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
        run_op(C_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        run_op(C_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(C_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0, 1'b0);
        run_op(C_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(C_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b1);
        run_op(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(C_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b1, 1'b0);
        run_op(C_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Async reset mid-MULT: no result is queued since the op is aborted.
        startE = 1'b1; opE = C_MULT; SrcAE = 32'h0000_0009; SrcBE = 32'h0000_0009;
        @(posedge clk); #1;
        startE = 1'b0; muldivD = 1'b1;
        repeat (9) @(posedge clk);
        #3;
        check("busy_before_reset", {62'd0, busy, stallMD}, 64'd3);
        reset = 1'b1;
        #1;
        check("reset_async_flags", {61'd0, busy, done, stallMD}, 64'd0);
        check("reset_async_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; muldivD = 1'b0;
        @(posedge clk); #1;
        run_op(C_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
